// File: rtl/regfile_mp_pkg.sv
// rf_pkg: shared state encoding, constants and clog2 helper for regfile_mp.
// Revision: 1.0
`default_nettype none

package rf_pkg;

   typedef enum logic [0:0] {
      RF_INIT  = 1'b0,
      RF_READY = 1'b1
   } rf_state_e;

   localparam int NUM_RD_MAX = 4;
   localparam int ZERO_REG   = 0;

   function automatic int rf_clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) begin
         r = r + 1;
      end
      return r;
   endfunction

endpackage : rf_pkg

`default_nettype wire

// File: rtl/regfile_mp_if.sv
// regfile_mp_if: write port, flattened read ports and status of regfile_mp.
// Revision: 1.0
`default_nettype none

interface regfile_mp_if
   import rf_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 32,
   parameter int NUM_RD = 2
);
   localparam int ADDR_W = rf_clog2(DEPTH);

   logic                       we;
   logic [ADDR_W-1:0]          wa;
   logic [DATA_W-1:0]          wd;
   logic [NUM_RD*ADDR_W-1:0]   ra;
   logic [NUM_RD*DATA_W-1:0]   rd;
   logic                       ready;
   logic                       wr_drop;

   modport master (
      output we, wa, wd, ra,
      input  rd, ready, wr_drop
   );

   modport slave (
      input  we, wa, wd, ra,
      output rd, ready, wr_drop
   );

endinterface : regfile_mp_if

`default_nettype wire

// File: rtl/regfile_mp_init_ctrl.sv
// rf_init_ctrl: post-reset clear sequencer (INIT/READY FSM), ready and wr_drop.
// Revision: 1.0
`default_nettype none

module rf_init_ctrl
   import rf_pkg::*;
#(
   parameter int DEPTH  = 32,
   parameter int ADDR_W = rf_clog2(DEPTH)
) (
   input  wire logic              clk,
   input  wire logic              rst_n,
   input  wire logic              i_we,
   output      logic              o_ready,
   output      logic              o_wr_drop,
   output      logic              o_clr_en,
   output      logic [ADDR_W-1:0] o_clr_addr,
   output      rf_state_e         o_state
);

   localparam logic [ADDR_W-1:0] c_LAST = ADDR_W'(DEPTH - 1);

   rf_state_e         r_state;
   rf_state_e         w_state_nxt;
   logic [ADDR_W-1:0] r_cnt;
   logic [ADDR_W-1:0] w_cnt_nxt;
   logic              r_wr_drop;
   logic              w_wr_drop_nxt;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state   <= RF_INIT;
         r_cnt     <= ADDR_W'(1);
         r_wr_drop <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_wr_drop <= w_wr_drop_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = r_cnt;
      w_wr_drop_nxt = 1'b0;
      case (r_state)
         RF_INIT: begin
            w_cnt_nxt     = r_cnt + ADDR_W'(1);
            w_wr_drop_nxt = i_we;
            // Leaving on the edge that clears the last entry makes ready rise with it.
            if (r_cnt == c_LAST) begin
               w_state_nxt = RF_READY;
            end
         end
         RF_READY: begin
            w_state_nxt = RF_READY;
         end
         default: begin
            w_state_nxt = RF_INIT;
         end
      endcase
   end

   assign o_ready    = (r_state == RF_READY);
   assign o_wr_drop  = r_wr_drop;
   assign o_clr_en   = (r_state == RF_INIT);
   assign o_clr_addr = r_cnt;
   assign o_state    = r_state;

endmodule : rf_init_ctrl

`default_nettype wire

// File: rtl/regfile_mp.sv
// regfile_mp: multi-read-port register file with x0 hardwired to zero and init clear.
// Optional macro REGFILE_MP_BYPASS_EN enables write-to-read forwarding. Revision: 1.0
`default_nettype none

module regfile_mp
   import rf_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 32,
   parameter int NUM_RD = 2,
   parameter int ADDR_W = rf_clog2(DEPTH)
) (
   input wire logic     clk,
   input wire logic     rst_n,
   regfile_mp_if.slave  bus
);

   localparam logic [ADDR_W-1:0] c_ZERO = ADDR_W'(ZERO_REG);

   if ((NUM_RD < 1) || (NUM_RD > NUM_RD_MAX)) begin : g_bad_num_rd
      $error("regfile_mp: NUM_RD must be in 1..%0d", NUM_RD_MAX);
   end

   logic [DATA_W-1:0]        r_rf [DEPTH];
   logic                     w_clr_en;
   logic [ADDR_W-1:0]        w_clr_addr;
   rf_state_e                w_state;
   logic                     w_ready;
   logic                     w_wr_drop;
   logic                     w_we;
   logic [ADDR_W-1:0]        w_waddr;
   logic [DATA_W-1:0]        w_wdata;
   logic [NUM_RD*DATA_W-1:0] w_rd;

   rf_init_ctrl #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_init_ctrl (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_we       (bus.we),
      .o_ready    (w_ready),
      .o_wr_drop  (w_wr_drop),
      .o_clr_en   (w_clr_en),
      .o_clr_addr (w_clr_addr),
      .o_state    (w_state)
   );

   // The array is left untouched while rst_n is low; entry 0 is never written.
   always_comb begin
      w_we    = 1'b0;
      w_waddr = w_clr_addr;
      w_wdata = '0;
      if (rst_n) begin
         if (w_clr_en) begin
            w_we = 1'b1;
         end else if ((w_state == RF_READY) && bus.we && (bus.wa != c_ZERO)) begin
            w_we    = 1'b1;
            w_waddr = bus.wa;
            w_wdata = bus.wd;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_we) begin
         r_rf[w_waddr] <= w_wdata;
      end
   end

   for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      logic [ADDR_W-1:0] w_ra;
      logic              w_byp;

      assign w_ra = bus.ra[k*ADDR_W +: ADDR_W];
`ifdef REGFILE_MP_BYPASS_EN
      assign w_byp = (w_state == RF_READY) && bus.we && (bus.wa != c_ZERO) && (w_ra == bus.wa);
`else
      assign w_byp = 1'b0;
`endif
      assign w_rd[k*DATA_W +: DATA_W] =
         ((w_state == RF_INIT) || (w_ra == c_ZERO)) ? '0 :
         w_byp                                      ? bus.wd :
                                                      r_rf[w_ra];
   end

   assign bus.rd      = w_rd;
   assign bus.ready   = w_ready;
   assign bus.wr_drop = w_wr_drop;

endmodule : regfile_mp

`default_nettype wire

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed table, hand sequences and randomized model check of regfile_mp.
// Revision: 1.0
`default_nettype none

module tb_regfile_mp;

`ifdef REGFILE_MP_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic clk;
   logic rst_n;
   logic rst2_n;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   regfile_mp_if #(.DATA_W(32), .DEPTH(32), .NUM_RD(2)) bus ();
   regfile_mp_if #(.DATA_W(64), .DEPTH(16), .NUM_RD(4)) bus2 ();

   regfile_mp #(.DATA_W(32), .DEPTH(32), .NUM_RD(2)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   regfile_mp #(.DATA_W(64), .DEPTH(16), .NUM_RD(4)) dut2 (
      .clk   (clk),
      .rst_n (rst2_n),
      .bus   (bus2)
   );

   int n_vec = 0;
   int n_err = 0;

   // Reference model: contents as the programmer sees them, plus init progress.
   logic [31:0] m_mem [32];
   bit          m_ready;
   bit          m_drop;
   int          m_edges;

   typedef struct {
      logic        we;
      logic [4:0]  wa;
      logic [31:0] wd;
      logic [4:0]  ra0;
      logic [4:0]  ra1;
      logic [31:0] e0;
      logic [31:0] e1;
   } vec_t;

   vec_t tbl [8];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] m_read(input logic [4:0] ra);
      if (!m_ready || ra == 5'd0) return 32'd0;
      if (BYP && bus.we && bus.wa != 5'd0 && ra == bus.wa) return bus.wd;
      return m_mem[ra];
   endfunction

   task automatic tick();
      if (!rst_n) begin
         for (int i = 0; i < 32; i++) m_mem[i] = 32'd0;
         m_edges = 0;
         m_ready = 1'b0;
         m_drop  = 1'b0;
      end else if (!m_ready) begin
         m_drop  = bus.we;
         m_edges = m_edges + 1;
         if (m_edges == 31) m_ready = 1'b1;
      end else begin
         m_drop = 1'b0;
         if (bus.we && bus.wa != 5'd0) m_mem[bus.wa] = bus.wd;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic check_model(input string tag);
      chk({tag, "_ready"}, 64'(bus.ready), 64'(m_ready));
      chk({tag, "_drop"},  64'(bus.wr_drop), 64'(m_drop));
      chk({tag, "_rd0"},   64'(bus.rd[31:0]),  64'(m_read(bus.ra[4:0])));
      chk({tag, "_rd1"},   64'(bus.rd[63:32]), 64'(m_read(bus.ra[9:5])));
   endtask

   task automatic wait_ready(input string name, input int exp_edges);
      int edges;
      edges = 0;
      while (!bus.ready && edges < 100) begin
         tick();
         edges++;
      end
      chk(name, 64'(edges), 64'(exp_edges));
   endtask

   initial begin
      int   edges2;
      logic [4:0] a;

      tbl[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd5,  BYP ? 32'hDEADBEEF : 32'd0, BYP ? 32'hDEADBEEF : 32'd0};
      tbl[1] = '{1'b1, 5'd0,  32'h00001234, 5'd5,  5'd0,  32'hDEADBEEF, 32'd0};
      tbl[2] = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd5,  32'd0, 32'hDEADBEEF};
      tbl[3] = '{1'b1, 5'd7,  32'h00000077, 5'd0,  5'd0,  32'd0, 32'd0};
      tbl[4] = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd7,  32'd0, 32'h77};
      tbl[5] = '{1'b1, 5'd12, 32'h00000011, 5'd7,  5'd12, 32'h77, BYP ? 32'h11 : 32'd0};
      tbl[6] = '{1'b1, 5'd12, 32'h00000055, 5'd12, 5'd12, BYP ? 32'h55 : 32'h11, BYP ? 32'h55 : 32'h11};
      tbl[7] = '{1'b0, 5'd0,  32'h0,        5'd12, 5'd5,  32'h55, 32'hDEADBEEF};

      rst_n  = 1'b0;
      rst2_n = 1'b0;
      bus.we = 1'b0; bus.wa = '0; bus.wd = '0; bus.ra = '0;
      bus2.we = 1'b0; bus2.wa = '0; bus2.wd = '0; bus2.ra = '0;
      tick();
      tick();
      chk("rst_ready", 64'(bus.ready), 64'd0);
      chk("rst_drop",  64'(bus.wr_drop), 64'd0);

      // Write attempted during INIT, then a reset at cycle 10 of INIT.
      rst_n = 1'b1;
      tick();
      chk("init_drop_c1", 64'(bus.wr_drop), 64'd0);
      bus.we = 1'b1; bus.wa = 5'd3; bus.wd = 32'hAA;
      tick();
      bus.we = 1'b0;
      chk("init_drop_c2", 64'(bus.wr_drop), 64'd1);
      tick();
      chk("init_drop_c3", 64'(bus.wr_drop), 64'd0);
      for (int i = 0; i < 7; i++) tick();
      chk("mid_init_ready", 64'(bus.ready), 64'd0);
      rst_n = 1'b0;
      tick();
      chk("mid_rst_ready", 64'(bus.ready), 64'd0);
      rst_n = 1'b1;
      wait_ready("init_len", 31);

      for (int i = 0; i < 32; i++) begin
         bus.ra = {5'(31 - i), 5'(i)};
         #1;
         chk("clr_rd0", 64'(bus.rd[31:0]), 64'd0);
         chk("clr_rd1", 64'(bus.rd[63:32]), 64'd0);
      end

      for (int i = 0; i < 8; i++) begin
         bus.we = tbl[i].we; bus.wa = tbl[i].wa; bus.wd = tbl[i].wd;
         bus.ra = {tbl[i].ra1, tbl[i].ra0};
         #1;
         chk("tbl_rd0", 64'(bus.rd[31:0]),  64'(tbl[i].e0));
         chk("tbl_rd1", 64'(bus.rd[63:32]), 64'(tbl[i].e1));
         chk("tbl_ready", 64'(bus.ready), 64'd1);
         tick();
         chk("tbl_drop", 64'(bus.wr_drop), 64'd0);
      end
      bus.we = 1'b0;

      // Reset while READY must clear rf[9].
      bus.we = 1'b1; bus.wa = 5'd9; bus.wd = 32'h99;
      tick();
      bus.we = 1'b0; bus.ra = {5'd0, 5'd9};
      #1;
      chk("r9_before", 64'(bus.rd[31:0]), 64'h99);
      rst_n = 1'b0;
      tick();
      chk("r9_rst_ready", 64'(bus.ready), 64'd0);
      rst_n = 1'b1;
      wait_ready("reinit_len", 31);
      chk("r9_after", 64'(bus.rd[31:0]), 64'd0);

      for (int i = 0; i < 600; i++) begin
         rst_n  = ($urandom_range(0, 249) != 0);
         bus.we = $urandom_range(0, 1);
         a      = 5'($urandom_range(0, 31));
         bus.wa = ($urandom_range(0, 7) == 0) ? 5'd0 : a;
         bus.wd = $urandom;
         bus.ra[4:0] = ($urandom_range(0, 3) == 0) ? bus.wa : 5'($urandom_range(0, 31));
         bus.ra[9:5] = ($urandom_range(0, 3) == 0) ? bus.wa : 5'($urandom_range(0, 31));
         #1;
         check_model("rnd");
         tick();
      end
      rst_n = 1'b1;

      // Wide/deep-4-port variant: read-during-write on every port.
      rst2_n = 1'b1;
      edges2 = 0;
      while (!bus2.ready && edges2 < 100) begin
         @(posedge clk); #1;
         edges2++;
      end
      chk("p4_init_len", 64'(edges2), 64'd15);
      bus2.we = 1'b1; bus2.wa = 4'd12; bus2.wd = 64'h11;
      @(posedge clk); #1;
      bus2.wd = 64'h55;
      bus2.ra = {4'd12, 4'd12, 4'd12, 4'd12};
      #1;
      for (int k = 0; k < 4; k++) begin
         chk("p4_rdw", bus2.rd[k*64 +: 64], BYP ? 64'h55 : 64'h11);
      end
      @(posedge clk); #1;
      bus2.we = 1'b0;
      bus2.ra = {4'd12, 4'd0, 4'd12, 4'd3};
      #1;
      chk("p4_after0", bus2.rd[63:0],    64'd0);
      chk("p4_after1", bus2.rd[127:64],  64'h55);
      chk("p4_after2", bus2.rd[191:128], 64'd0);
      chk("p4_after3", bus2.rd[255:192], 64'h55);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_regfile_mp

`default_nettype wire
